// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: op encodings and select-width helper.
package reg_bank_pkg;

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_INC  = 3'b010;
   localparam logic [2:0] OP_DEC  = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_SHR  = 3'b101;
   localparam logic [2:0] OP_CLR  = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   // Select width for n registers; never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Control/data bundle between the control unit (master) and the register bank (slave).
interface reg_bank_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREGS = 4
) ();
   import reg_bank_pkg::*;

   localparam int unsigned AW = sel_width(NREGS);

   logic             enable;
   logic [AW-1:0]    sel;
   logic [2:0]       op;
   logic [WIDTH-1:0] in;
   logic [AW-1:0]    rd_a_sel;
   logic [AW-1:0]    rd_b_sel;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;
   logic             carry;
   logic             zero;

   modport master (
      output enable, sel, op, in, rd_a_sel, rd_b_sel,
      input  rd_a, rd_b, carry, zero
   );

   modport slave (
      input  enable, sel, op, in, rd_a_sel, rd_b_sel,
      output rd_a, rd_b, carry, zero
   );

endinterface

// File: rtl/reg_bank_alu.sv
// Combinational op unit: computes the write-back value and carry for one register.
module reg_bank_alu #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] old_val,
   input  logic [WIDTH-1:0] load_val,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             valid
);
   import reg_bank_pkg::*;

   // Decode op; valid=0 for HOLD and the reserved encoding so nothing is written.
   always_comb begin
      result = old_val;
      carry  = 1'b0;
      valid  = 1'b1;
      case (op)
         OP_LOAD: result = load_val;
         OP_INC: begin
            result = old_val + WIDTH'(1);
            carry  = &old_val;
         end
         OP_DEC: begin
            result = old_val - WIDTH'(1);
            carry  = ~|old_val;
         end
         OP_SHL: begin
            result = {old_val[WIDTH-2:0], 1'b0};
            carry  = old_val[WIDTH-1];
         end
         OP_SHR: begin
            result = {1'b0, old_val[WIDTH-1:1]};
            carry  = old_val[0];
         end
         OP_CLR:  result = '0;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/reg_bank.sv
// Bank of NREGS registers with one op-driven write port, two read ports and
// registered carry/zero flags.
module reg_bank #(
   parameter int unsigned     WIDTH     = 8,
   parameter int unsigned     NREGS     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic       clk,
   input logic       reset,
   reg_bank_if.slave bus
);
   import reg_bank_pkg::*;

   localparam int unsigned AW = sel_width(NREGS);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic             carry_q;
   logic             zero_q;

   logic [WIDTH-1:0] old_val;
   logic [WIDTH-1:0] result;
   logic             alu_carry;
   logic             alu_valid;
   logic             sel_ok;
   logic             do_write;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   // Fetch the target register; out-of-range selects match nothing and block the write.
   always_comb begin
      old_val = '0;
      sel_ok  = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         if (bus.sel == AW'(i)) begin
            old_val = regs_q[i];
            sel_ok  = 1'b1;
         end
      end
      do_write = bus.enable & sel_ok & alu_valid;
   end

   reg_bank_alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .old_val (old_val),
      .load_val(bus.in),
      .op      (bus.op),
      .result  (result),
      .carry   (alu_carry),
      .valid   (alu_valid)
   );

   // Storage and flags: reset clears everything, otherwise only regs[sel] updates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else if (do_write) begin
         for (int i = 0; i < NREGS; i++) begin
            if (bus.sel == AW'(i)) begin
               regs_q[i] <= result;
            end
         end
         carry_q <= alu_carry;
         zero_q  <= (result == '0);
      end
   end

   // Read muxes; selects beyond the last register read as zero.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (bus.rd_a_sel == AW'(i)) rd_a = regs_q[i];
         if (bus.rd_b_sel == AW'(i)) rd_b = regs_q[i];
      end
   end

   assign bus.rd_a  = rd_a;
   assign bus.rd_b  = rd_b;
   assign bus.carry = carry_q;
   assign bus.zero  = zero_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: 4-register and 3-register instances,
// expected read/flag values queued at drive time and compared after the edge.
module tb_reg_bank;
   import reg_bank_pkg::*;

   typedef struct {
      string       name;
      logic [17:0] val;   // {rd_a, rd_b, carry, zero}
   } exp_t;

   typedef struct {
      string       name;
      logic        en;
      logic [1:0]  sel;
      logic [2:0]  op;
      logic [7:0]  din;
      logic [1:0]  ra;
      logic [1:0]  rb;
      logic [17:0] exp;
   } step_t;

   logic clk;
   logic reset;

   exp_t  exp_q[$];
   step_t steps[$];
   int    n_checks;
   int    n_fail;

   reg_bank_if #(.WIDTH(8), .NREGS(4)) bus4 ();
   reg_bank_if #(.WIDTH(8), .NREGS(3)) bus3 ();

   reg_bank #(.WIDTH(8), .NREGS(4), .RESET_VAL(8'h00)) dut4 (
      .clk  (clk),
      .reset(reset),
      .bus  (bus4)
   );

   reg_bank #(.WIDTH(8), .NREGS(3), .RESET_VAL(8'h00)) dut3 (
      .clk  (clk),
      .reset(reset),
      .bus  (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic step_t mk(input string name, input logic en, input logic [1:0] sel,
                                input logic [2:0] op, input logic [7:0] din,
                                input logic [1:0] ra, input logic [1:0] rb,
                                input logic [7:0] ea, input logic [7:0] eb,
                                input logic ec, input logic ez);
      step_t s;
      s.name = name; s.en = en; s.sel = sel; s.op = op; s.din = din;
      s.ra = ra; s.rb = rb; s.exp = {ea, eb, ec, ez};
      return s;
   endfunction

   function automatic logic [17:0] observed(input bit use3);
      if (use3) return {bus3.rd_a, bus3.rd_b, bus3.carry, bus3.zero};
      return {bus4.rd_a, bus4.rd_b, bus4.carry, bus4.zero};
   endfunction

   task automatic set_inputs(input bit use3, input logic en, input logic [1:0] sel,
                             input logic [2:0] op, input logic [7:0] din,
                             input logic [1:0] ra, input logic [1:0] rb);
      if (use3) begin
         bus3.enable = en; bus3.sel = sel; bus3.op = op; bus3.in = din;
         bus3.rd_a_sel = ra; bus3.rd_b_sel = rb;
      end else begin
         bus4.enable = en; bus4.sel = sel; bus4.op = op; bus4.in = din;
         bus4.rd_a_sel = ra; bus4.rd_b_sel = rb;
      end
   endtask

   // Drive one step, queue its post-edge expectation, and advance past the edge.
   task automatic drive_op(input bit use3, input step_t s);
      exp_t e;
      set_inputs(use3, s.en, s.sel, s.op, s.din, s.ra, s.rb);
      e.name = s.name;
      e.val  = s.exp;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t        e;
      logic [17:0] obs;
      steps.delete();
      steps.push_back(mk("rst_pre_load_r0", 1, 0, OP_LOAD, 8'h33, 0, 3, 8'h33, 8'h00, 0, 0));
      steps.push_back(mk("rst_pre_load_r3", 1, 3, OP_LOAD, 8'h44, 0, 3, 8'h33, 8'h44, 0, 0));
      steps.push_back(mk("rst_pre_load_r1", 1, 1, OP_LOAD, 8'h00, 1, 3, 8'h00, 8'h44, 0, 1));
      foreach (steps[i]) begin
         drive_op(0, steps[i]);
         e = exp_q.pop_front();
         obs = observed(0);
         n_checks++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got {a,b,c,z}=%h required %h", e.name, obs, e.val);
         end
      end
      // Async assert mid-cycle with a LOAD pending; outputs must clear before any edge.
      set_inputs(0, 1, 2, OP_LOAD, 8'h77, 0, 3);
      #2;
      reset = 1'b0;
      e.name = "rst_async_clear";
      e.val  = {8'h00, 8'h00, 1'b0, 1'b0};
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      obs = observed(0);
      n_checks++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got {a,b,c,z}=%h required %h", e.name, obs, e.val);
      end
      // Edge while reset is held: the pending LOAD of r2 must be dropped.
      set_inputs(0, 1, 2, OP_LOAD, 8'h77, 2, 1);
      e.name = "rst_abort_write";
      e.val  = {8'h00, 8'h00, 1'b0, 1'b0};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      obs = observed(0);
      n_checks++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got {a,b,c,z}=%h required %h", e.name, obs, e.val);
      end
      set_inputs(0, 0, 0, OP_HOLD, 8'h00, 0, 3);
      reset = 1'b1;
      steps.delete();
      steps.push_back(mk("rst_release_r0_r3", 0, 0, OP_HOLD, 8'h00, 0, 3, 8'h00, 8'h00, 0, 0));
      steps.push_back(mk("rst_release_r2_r1", 0, 0, OP_HOLD, 8'h00, 2, 1, 8'h00, 8'h00, 0, 0));
      foreach (steps[i]) begin
         drive_op(0, steps[i]);
         e = exp_q.pop_front();
         obs = observed(0);
         n_checks++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got {a,b,c,z}=%h required %h", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_load();
      exp_t        e;
      logic [17:0] obs;
      steps.delete();
      steps.push_back(mk("load_r1_0f",   1, 1, OP_LOAD, 8'h0F, 1, 2, 8'h0F, 8'h00, 0, 0));
      steps.push_back(mk("load_r2_fe",   1, 2, OP_LOAD, 8'hFE, 1, 2, 8'h0F, 8'hFE, 0, 0));
      steps.push_back(mk("load_r0_r3_0", 1, 0, OP_HOLD, 8'hAA, 0, 3, 8'h00, 8'h00, 0, 0));
      foreach (steps[i]) begin
         drive_op(0, steps[i]);
         e = exp_q.pop_front();
         obs = observed(0);
         n_checks++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got {a,b,c,z}=%h required %h", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_inc_dec();
      exp_t        e;
      logic [17:0] obs;
      steps.delete();
      steps.push_back(mk("inc_r2_fe_ff", 1, 2, OP_INC, 8'h00, 2, 1, 8'hFF, 8'h0F, 0, 0));
      steps.push_back(mk("inc_r2_ff_00", 1, 2, OP_INC, 8'h00, 2, 1, 8'h00, 8'h0F, 1, 1));
      steps.push_back(mk("dec_r0_00_ff", 1, 0, OP_DEC, 8'h00, 0, 2, 8'hFF, 8'h00, 1, 0));
      foreach (steps[i]) begin
         drive_op(0, steps[i]);
         e = exp_q.pop_front();
         obs = observed(0);
         n_checks++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got {a,b,c,z}=%h required %h", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_enable();
      exp_t        e;
      logic [17:0] obs;
      steps.delete();
      steps.push_back(mk("en0_load_r1", 0, 1, OP_LOAD, 8'h55, 1, 0, 8'h0F, 8'hFF, 1, 0));
      steps.push_back(mk("en0_clr_r0",  0, 0, OP_CLR,  8'h00, 0, 1, 8'hFF, 8'h0F, 1, 0));
      steps.push_back(mk("en1_load_r1", 1, 1, OP_LOAD, 8'h55, 1, 0, 8'h55, 8'hFF, 0, 0));
      foreach (steps[i]) begin
         drive_op(0, steps[i]);
         e = exp_q.pop_front();
         obs = observed(0);
         n_checks++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got {a,b,c,z}=%h required %h", e.name, obs, e.val);
         end
      end
   endtask

   task automatic test_shift();
      exp_t        e;
      logic [17:0] obs;
      steps.delete();
      steps.push_back(mk("shl_load_81",  1, 1, OP_LOAD, 8'h81, 1, 0, 8'h81, 8'hFF, 0, 0));
      steps.push_back(mk("shl_81_02",    1, 1, OP_SHL,  8'h00, 1, 0, 8'h02, 8'hFF, 1, 0));
      steps.push_back(mk("shr_02_01",    1, 1, OP_SHR,  8'h00, 1, 0, 8'h01, 8'hFF, 0, 0));
      steps.push_back(mk("shr_load_01",  1, 3, OP_LOAD, 8'h01, 3, 1, 8'h01, 8'h01, 0, 0));
      steps.push_back(mk("shr_01_00",    1, 3, OP_SHR,  8'h00, 3, 1, 8'h00, 8'h01, 1, 1));
      steps.push_back(mk("rsvd_no_chg",  1, 3, OP_RSVD, 8'h5A, 3, 1, 8'h00, 8'h01, 1, 1));
      steps.push_back(mk("clr_r0",       1, 0, OP_CLR,  8'h00, 0, 3, 8'h00, 8'h00, 0, 1));
      steps.push_back(mk("hold_r2_r1",   1, 0, OP_HOLD, 8'h00, 2, 1, 8'h00, 8'h01, 0, 1));
      foreach (steps[i]) begin
         drive_op(0, steps[i]);
         e = exp_q.pop_front();
         obs = observed(0);
         n_checks++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got {a,b,c,z}=%h required %h", e.name, obs, e.val);
         end
      end
      set_inputs(0, 0, 0, OP_HOLD, 8'h00, 0, 0);
   endtask

   task automatic test_nregs3();
      exp_t        e;
      logic [17:0] obs;
      // Read-during-write: old value visible before the edge, new value after.
      set_inputs(1, 1, 1, OP_LOAD, 8'hA5, 1, 0);
      e.name = "n3_rdw_old";
      e.val  = {8'h00, 8'h00, 1'b0, 1'b0};
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      obs = observed(1);
      n_checks++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got {a,b,c,z}=%h required %h", e.name, obs, e.val);
      end
      e.name = "n3_rdw_new";
      e.val  = {8'hA5, 8'h00, 1'b0, 1'b0};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      obs = observed(1);
      n_checks++;
      if (obs !== e.val) begin
         n_fail++;
         $display("FAIL %s: got {a,b,c,z}=%h required %h", e.name, obs, e.val);
      end
      steps.delete();
      steps.push_back(mk("n3_load_r2",     1, 2, OP_LOAD, 8'h3C, 2, 1, 8'h3C, 8'hA5, 0, 0));
      steps.push_back(mk("n3_dec_r0",      1, 0, OP_DEC,  8'h00, 0, 2, 8'hFF, 8'h3C, 1, 0));
      steps.push_back(mk("n3_load_sel3",   1, 3, OP_LOAD, 8'h00, 3, 0, 8'h00, 8'hFF, 1, 0));
      steps.push_back(mk("n3_inc_sel3",    1, 3, OP_INC,  8'h00, 1, 2, 8'hA5, 8'h3C, 1, 0));
      steps.push_back(mk("n3_clr_sel3",    1, 3, OP_CLR,  8'h00, 3, 1, 8'h00, 8'hA5, 1, 0));
      foreach (steps[i]) begin
         drive_op(1, steps[i]);
         e = exp_q.pop_front();
         obs = observed(1);
         n_checks++;
         if (obs !== e.val) begin
            n_fail++;
            $display("FAIL %s: got {a,b,c,z}=%h required %h", e.name, obs, e.val);
         end
      end
      set_inputs(1, 0, 0, OP_HOLD, 8'h00, 0, 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      set_inputs(0, 0, 0, OP_HOLD, 8'h00, 0, 0);
      set_inputs(1, 0, 0, OP_HOLD, 8'h00, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      test_reset();
      test_load();
      test_inc_dec();
      test_enable();
      test_shift();
      test_nregs3();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
